// File: rtl/mdio_phy_responder_pkg.sv
// Shared types and constants for the Clause-22 MDIO PHY responder.
// Holds the frame FSM state enum, frame codes and register addresses.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST_CODE  = 2'b01;

    localparam logic [4:0] REG_CTRL = 5'd0;
    localparam logic [4:0] REG_STAT = 5'd1;
    localparam logic [4:0] REG_ID1  = 5'd2;
    localparam logic [4:0] REG_ID2  = 5'd3;

    localparam int CTRL_RST_BIT = 15;

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO pad bundle: i = pad input, o/oe = drive value/enable.
// master = controller side, slave = PHY responder side.
interface mdio_phy_responder_if;
    logic mdio_i;
    logic mdio_o;
    logic mdio_oe;

    modport master (
        output mdio_i,
        input  mdio_o,
        input  mdio_oe
    );

    modport slave (
        input  mdio_i,
        output mdio_o,
        output mdio_oe
    );
endinterface

// File: rtl/mdio_phy_responder_reg_file.sv
// MDIO register file: RW storage, RO mux, self-clearing soft reset.
// Ports: we/waddr/wdata write, raddr/rdata read, status_i, ctrl.
module mdio_reg_file
    import mdio_pkg::*;
#(
    parameter int          NUM_REGS = 32,
    parameter logic [15:0] PHY_ID1  = 16'h0022,
    parameter logic [15:0] PHY_ID2  = 16'h1560
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [4:0]  raddr,
    output logic [15:0] rdata,
    input  logic [15:0] status_i,
    output logic [15:0] ctrl
);

    localparam logic [5:0] NREG = 6'(NUM_REGS);

    logic [15:0] mem [32];
    logic        gen_w;
    logic        gen_r;

    assign gen_w = we && (waddr >= 5'd4)
                   && ({1'b0, waddr} < NREG);
    assign gen_r = (raddr >= 5'd4)
                   && ({1'b0, raddr} < NREG);

    // Soft reset returns every RW register to
    // its reset value, so bit15 reads back 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '0;
            for (int i = 0; i < 32; i++)
                mem[i] <= '0;
        end else if (we && waddr == REG_CTRL) begin
            if (wdata[CTRL_RST_BIT]) begin
                ctrl <= '0;
                for (int i = 0; i < 32; i++)
                    mem[i] <= '0;
            end else begin
                ctrl <= wdata;
            end
        end else if (gen_w) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (raddr == REG_CTRL): rdata = ctrl;
            (raddr == REG_STAT): rdata = status_i;
            (raddr == REG_ID1):  rdata = PHY_ID1;
            (raddr == REG_ID2):  rdata = PHY_ID2;
            gen_r:               rdata = mem[raddr];
            default:             rdata = '0;
        endcase
    end

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side target clocked by MDC (clk).
// Ports: mdio bundle, status_i, ctrl_o, wr_*/rd_strobe, frame_err.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int          NUM_REGS     = 32,
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1560
) (
    input  logic                clk,
    input  logic                rst_n,
    mdio_phy_responder_if.slave mdio,
    input  logic [15:0]         status_i,
    output logic [15:0]         ctrl_o,
    output logic                wr_strobe,
    output logic [4:0]          wr_addr,
    output logic [15:0]         wr_data,
    output logic                rd_strobe,
    output logic                frame_err
);

    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PW-1:0] PRE_MAX =
        PW'(PREAMBLE_LEN);

    state_t        state_q, state_d;
    logic [PW-1:0] pre_cnt;
    logic [3:0]    bit_cnt;
    logic          op_b0, op_rd, phy_match;
    logic [3:0]    phy_sh, reg_sh;
    logic [4:0]    reg_addr, regad;
    logic [14:0]   wr_sh;
    logic [15:0]   rd_sh, rdata, commit_data;
    logic          bad_frame, rd_accept, commit;
    logic          pre_done, drive_o, drive_oe;
    logic          din;

    assign din         = mdio.mdio_i;
    assign regad       = {reg_sh, din};
    assign commit_data = {wr_sh, din};
    assign pre_done    = pre_cnt >= PRE_MAX;
    assign mdio.mdio_o  = drive_o;
    assign mdio.mdio_oe = drive_oe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_PRE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        bad_frame = 1'b0;
        rd_accept = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            S_PRE:
                if (din == ST_CODE[1] && pre_done)
                    state_d = S_ST;
            S_ST:
                if (din == ST_CODE[0]) begin
                    state_d = S_OP;
                end else begin
                    state_d   = S_PRE;
                    bad_frame = 1'b1;
                end
            S_OP:
                if (bit_cnt[0]) begin
                    if ({op_b0, din} == OP_READ ||
                        {op_b0, din} == OP_WRITE) begin
                        state_d = S_PHYAD;
                    end else begin
                        state_d   = S_PRE;
                        bad_frame = 1'b1;
                    end
                end
            S_PHYAD:
                if (bit_cnt == 4'd4) state_d = S_REGAD;
            S_REGAD:
                if (bit_cnt == 4'd4) begin
                    state_d   = S_TA;
                    rd_accept = phy_match & op_rd;
                end
            S_TA:
                if (bit_cnt[0]) state_d = S_DATA;
            S_DATA:
                if (bit_cnt == 4'd15) begin
                    state_d = S_PRE;
                    commit  = phy_match & ~op_rd;
                end
            default: state_d = S_PRE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            op_b0     <= 1'b0;
            op_rd     <= 1'b0;
            phy_match <= 1'b0;
            phy_sh    <= '0;
            reg_sh    <= '0;
            reg_addr  <= '0;
            wr_sh     <= '0;
            rd_sh     <= '0;
            drive_o   <= 1'b0;
            drive_oe  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rd_strobe <= rd_accept;
            frame_err <= bad_frame;
            wr_strobe <= commit;
            if (commit) begin
                wr_addr <= reg_addr;
                wr_data <= commit_data;
            end
            bit_cnt <= (state_d != state_q) ?
                       4'd0 : bit_cnt + 4'd1;
            // Saturating run of 1s; any other bit or
            // state restarts the preamble from zero.
            if (state_q == S_PRE && din) begin
                if (!pre_done)
                    pre_cnt <= pre_cnt + PW'(1);
            end else begin
                pre_cnt <= '0;
            end
            if (state_q == S_OP) begin
                if (!bit_cnt[0]) op_b0 <= din;
                else op_rd <= ({op_b0, din} == OP_READ);
            end
            if (state_q == S_PHYAD) begin
                phy_sh <= {phy_sh[2:0], din};
                if (bit_cnt == 4'd4)
                    phy_match <= ({phy_sh, din} == PHY_ADDR);
            end
            if (state_q == S_REGAD) begin
                reg_sh <= {reg_sh[2:0], din};
                if (bit_cnt == 4'd4) begin
                    reg_addr <= regad;
                    rd_sh    <= rdata;
                end
            end
            if (state_q == S_DATA)
                wr_sh <= {wr_sh[13:0], din};
            // First TA edge: take the bus driving 0.
            // Then launch D15..D0, release on last edge.
            if (state_q == S_TA && !bit_cnt[0]) begin
                if (phy_match && op_rd) begin
                    drive_oe <= 1'b1;
                    drive_o  <= 1'b0;
                end
            end else if (state_q == S_DATA &&
                         bit_cnt == 4'd15) begin
                drive_oe <= 1'b0;
                drive_o  <= 1'b0;
            end else if ((state_q == S_TA ||
                          state_q == S_DATA) && drive_oe) begin
                drive_o <= rd_sh[15];
                rd_sh   <= {rd_sh[14:0], 1'b0};
            end
        end
    end

    mdio_reg_file #(
        .NUM_REGS (NUM_REGS),
        .PHY_ID1  (PHY_ID1),
        .PHY_ID2  (PHY_ID2)
    ) u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (commit),
        .waddr    (reg_addr),
        .wdata    (commit_data),
        .raddr    (regad),
        .rdata    (rdata),
        .status_i (status_i),
        .ctrl     (ctrl_o)
    );

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: frame table plus
// hand sequences for mid-frame reset and status readback.
module tb_mdio_phy_responder;
    import mdio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] status_i;
    logic [15:0] ctrl_o;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_strobe;
    logic        frame_err;

    mdio_phy_responder_if bus ();

    always #5 clk = ~clk;

    mdio_phy_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mdio      (bus),
        .status_i  (status_i),
        .ctrl_o    (ctrl_o),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_strobe (rd_strobe),
        .frame_err (frame_err)
    );

    typedef struct {
        int          pre;
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic [15:0] stat;
        logic        drive;
        logic [15:0] rdat;
        int          nrd;
        int          nwr;
        int          nfe;
        logic [15:0] ctrl;
    } vec_t;

    vec_t vecs[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rd, n_wr, n_fe, ep;
    logic        oe_any;
    logic [18:0] oe_pat, o_pat;
    logic [4:0]  last_wa;
    logic [15:0] last_wd;

    function automatic vec_t mk(
        int pre, logic [1:0] st, logic [1:0] op,
        logic [4:0] phy, logic [4:0] ra,
        logic [15:0] wd, logic [15:0] stat,
        logic drive, logic [15:0] rdat,
        int nrd, int nwr, int nfe, logic [15:0] ctrl);
        vec_t v;
        v.pre = pre; v.st = st; v.op = op;
        v.phy = phy; v.ra = ra; v.wd = wd;
        v.stat = stat; v.drive = drive;
        v.rdat = rdat; v.nrd = nrd; v.nwr = nwr;
        v.nfe = nfe; v.ctrl = ctrl;
        return v;
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic clk_bit(input logic b);
        @(negedge clk);
        bus.mdio_i = b;
        @(posedge clk);
        #1;
        if (rd_strobe) n_rd++;
        if (wr_strobe) begin
            n_wr++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (frame_err) n_fe++;
        if (bus.mdio_oe) oe_any = 1'b1;
        if (ep >= 0 && ep <= 18) begin
            oe_pat[ep] = bus.mdio_oe;
            o_pat[ep]  = bus.mdio_o;
        end
        if (ep >= 0) ep++;
    endtask

    function automatic logic [15:0] pat_data();
        logic [15:0] d;
        for (int k = 0; k < 16; k++)
            d[15-k] = o_pat[2+k];
        return d;
    endfunction

    task automatic frame(input int pre,
                         input logic [1:0] st,
                         input logic [1:0] op,
                         input logic [4:0] phy,
                         input logic [4:0] ra,
                         input logic [15:0] wd,
                         input int abort_bit);
        logic is_wr;
        is_wr  = (op == OP_WRITE);
        n_rd   = 0;
        n_wr   = 0;
        n_fe   = 0;
        ep     = -1;
        oe_any = 1'b0;
        oe_pat = '0;
        o_pat  = '0;
        clk_bit(1'b0);
        repeat (pre) clk_bit(1'b1);
        clk_bit(st[1]);
        clk_bit(st[0]);
        clk_bit(op[1]);
        clk_bit(op[0]);
        for (int i = 4; i >= 0; i--) clk_bit(phy[i]);
        for (int i = 4; i >= 1; i--) clk_bit(ra[i]);
        ep = 0;
        clk_bit(ra[0]);
        clk_bit(1'b1);
        clk_bit(is_wr ? 1'b0 : 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k == abort_bit) begin
                check("pre_rst_oe", bus.mdio_oe,
                      (op == OP_READ && phy == 5'd1));
                #2 rst_n = 1'b0;
                #1;
                check("rst_oe_async", bus.mdio_oe, 0);
                check("rst_o_async", bus.mdio_o, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            clk_bit(is_wr ? wd[15-k] : 1'b1);
        end
        clk_bit(1'b1);
        clk_bit(1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst_n      = 1'b1;
        bus.mdio_i = 1'b1;
        status_i   = '0;

        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, 16'h0, 1, 16'h0022, 1, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b01, 5'd1, 5'd4, 16'hA5C3, 16'h0, 0, 16'h0, 0, 1, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 16'h0, 1, 16'hA5C3, 1, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd7, 5'd2, 16'h0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd3, 16'h0, 16'h0, 1, 16'h1560, 1, 0, 0, 16'h0));
        vecs.push_back(mk(31, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b00, 2'b10, 5'd1, 5'd2, 16'h0, 16'h0, 0, 16'h0, 0, 0, 1, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b11, 5'd1, 5'd2, 16'h0, 16'h0, 0, 16'h0, 0, 0, 1, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b01, 5'd1, 5'd0, 16'h1140, 16'h0, 0, 16'h0, 0, 1, 0, 16'h1140));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0, 16'h0, 1, 16'h1140, 1, 0, 0, 16'h1140));
        vecs.push_back(mk(32, 2'b01, 2'b01, 5'd1, 5'd4, 16'h1234, 16'h0, 0, 16'h0, 0, 1, 0, 16'h1140));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 16'h0, 1, 16'h1234, 1, 0, 0, 16'h1140));
        vecs.push_back(mk(32, 2'b01, 2'b01, 5'd1, 5'd0, 16'h8000, 16'h0, 0, 16'h0, 0, 1, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0, 16'h0, 1, 16'h0000, 1, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 16'h0, 1, 16'h0000, 1, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b01, 5'd1, 5'd2, 16'hFFFF, 16'h0, 0, 16'h0, 0, 1, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, 16'h0, 1, 16'h0022, 1, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0, 16'h796D, 1, 16'h796D, 1, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b01, 5'd7, 5'd4, 16'h5555, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 16'h0, 1, 16'h0000, 1, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b01, 5'd1, 5'd31, 16'hBEEF, 16'h0, 0, 16'h0, 0, 1, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b10, 5'd1, 5'd31, 16'h0, 16'h0, 1, 16'hBEEF, 1, 0, 0, 16'h0));
        vecs.push_back(mk(40, 2'b01, 2'b10, 5'd1, 5'd3, 16'h0, 16'h0, 1, 16'h1560, 1, 0, 0, 16'h0));
        vecs.push_back(mk(32, 2'b01, 2'b01, 5'd1, 5'd0, 16'h0100, 16'h0, 0, 16'h0, 0, 1, 0, 16'h0100));

        #2 rst_n = 1'b0;
        #1;
        check("rst_oe", bus.mdio_oe, 0);
        check("rst_o", bus.mdio_o, 0);
        check("rst_ctrl", ctrl_o, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_strobe", rd_strobe, 0);
        check("rst_frame_err", frame_err, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_oe", bus.mdio_oe, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            status_i = v.stat;
            frame(v.pre, v.st, v.op, v.phy, v.ra, v.wd, -1);
            check($sformatf("v%0d_rd_strobe", i), n_rd, v.nrd);
            check($sformatf("v%0d_wr_strobe", i), n_wr, v.nwr);
            check($sformatf("v%0d_frame_err", i), n_fe, v.nfe);
            check($sformatf("v%0d_oe_any", i), oe_any, v.drive);
            check($sformatf("v%0d_oe_pattern", i), oe_pat,
                  v.drive ? 19'h3FFFE : 19'h0);
            if (v.drive) begin
                check($sformatf("v%0d_ta_o", i), o_pat[1], 0);
                check($sformatf("v%0d_rdata", i), pat_data(), v.rdat);
            end
            if (v.nwr == 1) begin
                check($sformatf("v%0d_wr_addr", i), last_wa, v.ra);
                check($sformatf("v%0d_wr_data", i), last_wd, v.wd);
            end
            check($sformatf("v%0d_ctrl", i), ctrl_o, v.ctrl);
        end

        status_i = 16'h0;
        frame(32, 2'b01, 2'b01, 5'd1, 5'd5, 16'hABCD, 8);
        check("abort_wr_strobe", n_wr, 0);
        check("abort_ctrl", ctrl_o, 0);
        check("abort_wr_data", wr_data, 0);
        check("abort_wr_addr", wr_addr, 0);

        frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, 8);
        check("abort_rd_oe_after", bus.mdio_oe, 0);

        status_i = 16'hC3A5;
        frame(32, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0, -1);
        check("post_rst_rd_strobe", n_rd, 1);
        check("post_rst_status", pat_data(), 16'hC3A5);

        status_i = 16'h0;
        frame(32, 2'b01, 2'b10, 5'd1, 5'd5, 16'h0, -1);
        check("no_partial_commit", pat_data(), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
